// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the 32x32 register file: merges ALU and LSU writebacks
// into one write port, tracks outstanding loads and stalls decode on hazards.
module regfile_wb_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_wb_valid,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        lsu_wb_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_wb_ready,
  input  logic        issue_valid,
  input  logic        issue_is_load,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        dec_stall,
  output logic        ex_hold,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] pending,
  output logic        err_drop
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    logic [31:0] v;
    v      = 32'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [3:0]  r_starve;
  logic        r_hold;
  logic        r_wb_en;
  logic        r_wb_src_lsu;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic [31:0] r_pending;
  logic        r_err_drop;

  logic        w_ready;
  logic        w_ex_grant;
  logic        w_lsu_acc;
  logic        w_stall;
  logic        w_set;
  logic        w_clr;
  logic [3:0]  w_starve_nxt;
  logic [31:0] w_pending_nxt;

  assign w_ready    = r_hold | ~ex_wb_valid;
  assign w_ex_grant = ex_wb_valid & ~r_hold;
  assign w_lsu_acc  = lsu_wb_valid & w_ready;

  // x0 never holds a pending load, but each operand term is masked explicitly anyway
  assign w_stall = ((dec_rs1 != 5'd0) & r_pending[dec_rs1])
                 | ((dec_rs2 != 5'd0) & r_pending[dec_rs2])
                 | ((dec_rd  != 5'd0) & r_pending[dec_rd]);

  assign w_set = issue_valid & issue_is_load & ~w_stall & (issue_rd != 5'd0);
  assign w_clr = r_wb_en & r_wb_src_lsu;

  // Scoreboard next state: clear first so a same-edge set of the same bit wins
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_clr) begin
      w_pending_nxt = w_pending_nxt & ~onehot32(r_wb_rd);
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
    if (w_set) begin
      w_pending_nxt = w_pending_nxt | onehot32(issue_rd);
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Starvation counter next state, saturating at the limit
  always_comb begin
    w_starve_nxt = 4'd0;
    if (lsu_wb_valid && !w_ready) begin
      if (r_starve == LIMIT) begin
        w_starve_nxt = r_starve;
      end else begin
        w_starve_nxt = r_starve + 4'd1;
      end
    end else begin
      w_starve_nxt = 4'd0;
    end
  end

  // Starvation counter and the registered hold request derived from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
      r_hold   <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      r_hold   <= (w_starve_nxt == LIMIT);
    end
  end

  // Write stage: register the granted source; rd==0 suppresses the enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_en      <= 1'b0;
      r_wb_src_lsu <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_wb_data    <= 32'd0;
    end else if (w_ex_grant) begin
      r_wb_en      <= (ex_rd != 5'd0);
      r_wb_src_lsu <= 1'b0;
      r_wb_rd      <= ex_rd;
      r_wb_data    <= ex_data;
    end else if (w_lsu_acc) begin
      r_wb_en      <= (lsu_rd != 5'd0);
      r_wb_src_lsu <= 1'b1;
      r_wb_rd      <= lsu_rd;
      r_wb_data    <= lsu_data;
    end else begin
      r_wb_en      <= 1'b0;
      r_wb_src_lsu <= 1'b0;
      r_wb_rd      <= r_wb_rd;
      r_wb_data    <= r_wb_data;
    end
  end

  // Load scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Sticky flag: an ALU result presented while the port is held for the LSU is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_drop <= 1'b0;
    end else if (ex_wb_valid && r_hold) begin
      r_err_drop <= 1'b1;
    end else begin
      r_err_drop <= r_err_drop;
    end
  end

  assign lsu_wb_ready = w_ready;
  assign dec_stall    = w_stall;
  assign ex_hold      = r_hold;
  assign wb_en        = r_wb_en;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign pending      = r_pending;
  assign err_drop     = r_err_drop;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: expected writes queued at stimulus
// time and popped by a monitor whenever the write port fires.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst_n;
  logic        ex_wb_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        lsu_wb_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_wb_ready;
  logic        issue_valid;
  logic        issue_is_load;
  logic [4:0]  issue_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_stall;
  logic        ex_hold;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] pending;
  logic        err_drop;

  int vectors;
  int miscompares;
  logic [36:0] exp_q[$];
  logic [36:0] m_exp;

  regfile_wb_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_wb_valid(ex_wb_valid), .ex_rd(ex_rd), .ex_data(ex_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_wb_ready(lsu_wb_ready),
    .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_stall(dec_stall), .ex_hold(ex_hold),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .pending(pending), .err_drop(err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every committed write must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_en === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got write x%0d=%h, expected none", wb_rd, wb_data);
      end else begin
        m_exp = exp_q.pop_front();
        if ({wb_rd, wb_data} !== m_exp) begin
          miscompares++;
          $display("FAIL sb_write: got x%0d=%h, expected x%0d=%h",
                   wb_rd, wb_data, m_exp[36:32], m_exp[31:0]);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_wb_valid = 1'b0; ex_rd = 5'd0; ex_data = 32'd0;
    lsu_wb_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_inputs();
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ex_wb_valid = 1'($urandom_range(0, 1)); ex_rd = 5'($urandom); ex_data = $urandom;
      lsu_wb_valid = 1'($urandom_range(0, 1)); lsu_rd = 5'($urandom); lsu_data = $urandom;
      issue_valid = 1'($urandom_range(0, 1)); issue_is_load = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom);
      @(negedge clk);
      vectors++;
      if ({wb_en, pending, ex_hold, err_drop} !== 35'd0) begin
        miscompares++;
        $display("FAIL reset_state: got wb_en=%b pending=%h ex_hold=%b err_drop=%b, expected all 0",
                 wb_en, pending, ex_hold, err_drop);
      end
      vectors++;
      if ({wb_rd, wb_data} !== 37'd0) begin
        miscompares++;
        $display("FAIL reset_wb: got x%0d=%h, expected x0=0", wb_rd, wb_data);
      end
    end
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_arbitration();
    ex_wb_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'h11;
    lsu_wb_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h22;
    exp_q.push_back({5'd5, 32'h11});
    @(negedge clk);
    vectors++;
    if (lsu_wb_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL arb_ready_n: got %b, expected 0", lsu_wb_ready);
    end
    next_cycle();
    ex_wb_valid = 1'b0;
    exp_q.push_back({5'd6, 32'h22});
    @(negedge clk);
    vectors++;
    if ({wb_en, wb_rd, wb_data, lsu_wb_ready} !== {1'b1, 5'd5, 32'h11, 1'b1}) begin
      miscompares++;
      $display("FAIL arb_n1: got en=%b x%0d=%h ready=%b, expected en=1 x5=11 ready=1",
               wb_en, wb_rd, wb_data, lsu_wb_ready);
    end
    next_cycle();
    lsu_wb_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd6, 32'h22}) begin
      miscompares++;
      $display("FAIL arb_n2: got en=%b x%0d=%h, expected en=1 x6=22", wb_en, wb_rd, wb_data);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (wb_en !== 1'b0) begin
      miscompares++;
      $display("FAIL arb_idle: got wb_en=%b, expected 0", wb_en);
    end
    next_cycle();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    vectors++;
    if (dec_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_issue_stall: got %b, expected 0", dec_stall);
    end
    next_cycle();
    issue_valid = 1'b0; issue_is_load = 1'b0; dec_rs1 = 5'd7;
    @(negedge clk);
    vectors++;
    if ({pending, dec_stall} !== {32'h80, 1'b1}) begin
      miscompares++;
      $display("FAIL sb_rs1: got pending=%h stall=%b, expected 00000080 1", pending, dec_stall);
    end
    next_cycle();
    dec_rs1 = 5'd0; dec_rs2 = 5'd7;
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd8;
    @(negedge clk);
    vectors++;
    if (dec_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_rs2: got stall=%b, expected 1", dec_stall);
    end
    next_cycle();
    issue_valid = 1'b0; issue_is_load = 1'b0; dec_rs2 = 5'd0; dec_rd = 5'd7;
    @(negedge clk);
    vectors++;
    if ({pending, dec_stall} !== {32'h80, 1'b1}) begin
      miscompares++;
      $display("FAIL sb_rd_waw: got pending=%h stall=%b, expected 00000080 1", pending, dec_stall);
    end
    next_cycle();
    dec_rd = 5'd0; dec_rs1 = 5'd7;
    lsu_wb_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    exp_q.push_back({5'd7, 32'h77});
    @(negedge clk);
    vectors++;
    if ({dec_stall, lsu_wb_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL sb_accept: got stall=%b ready=%b, expected 1 1", dec_stall, lsu_wb_ready);
    end
    next_cycle();
    lsu_wb_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wb_en, wb_rd, dec_stall} !== {1'b1, 5'd7, 1'b1}) begin
      miscompares++;
      $display("FAIL sb_commit: got en=%b rd=%0d stall=%b, expected 1 7 1", wb_en, wb_rd, dec_stall);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({pending, dec_stall} !== {32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL sb_release: got pending=%h stall=%b, expected 0 0", pending, dec_stall);
    end
    dec_rs1 = 5'd0;
    next_cycle();
  endtask

  task automatic test_x0();
    ex_wb_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hdead;
    next_cycle();
    ex_wb_valid = 1'b0;
    lsu_wb_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hbeef;
    @(negedge clk);
    vectors++;
    if (wb_en !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_alu: got wb_en=%b, expected 0", wb_en);
    end
    next_cycle();
    lsu_wb_valid = 1'b0;
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    vectors++;
    if ({wb_en, dec_stall} !== 2'b00) begin
      miscompares++;
      $display("FAIL x0_lsu: got wb_en=%b stall=%b, expected 0 0", wb_en, dec_stall);
    end
    next_cycle();
    issue_valid = 1'b0; issue_is_load = 1'b0;
    @(negedge clk);
    vectors++;
    if ({pending, dec_stall, wb_en} !== 34'd0) begin
      miscompares++;
      $display("FAIL x0_load: got pending=%h stall=%b en=%b, expected 0 0 0", pending, dec_stall, wb_en);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        ex_wb_valid = 1'b1; ex_rd = 5'(i + 1); ex_data = 32'(32'hA0 + i);
        lsu_wb_valid = 1'b0;
        exp_q.push_back({5'(i + 1), 32'(32'hA0 + i)});
      end else begin
        ex_wb_valid = 1'b0;
        lsu_wb_valid = 1'b1; lsu_rd = 5'(i + 1); lsu_data = 32'(32'hB0 + i);
        exp_q.push_back({5'(i + 1), 32'(32'hB0 + i)});
      end
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if ({wb_en, wb_rd} !== {1'b1, 5'(i)}) begin
          miscompares++;
          $display("FAIL b2b_%0d: got en=%b rd=%0d, expected 1 %0d", i, wb_en, wb_rd, i);
        end
      end
      next_cycle();
    end
    ex_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wb_en, wb_rd} !== {1'b1, 5'd4}) begin
      miscompares++;
      $display("FAIL b2b_last: got en=%b rd=%0d, expected 1 4", wb_en, wb_rd);
    end
    next_cycle();
  endtask

  task automatic test_collision();
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd9;
    next_cycle();
    issue_valid = 1'b0; issue_is_load = 1'b0;
    lsu_wb_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    exp_q.push_back({5'd9, 32'h99});
    @(negedge clk);
    vectors++;
    if (pending !== 32'h200) begin
      miscompares++;
      $display("FAIL col_set: got pending=%h, expected 00000200", pending);
    end
    next_cycle();
    lsu_wb_valid = 1'b0;
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    vectors++;
    if ({wb_en, wb_rd, dec_stall} !== {1'b1, 5'd9, 1'b0}) begin
      miscompares++;
      $display("FAIL col_commit: got en=%b rd=%0d stall=%b, expected 1 9 0", wb_en, wb_rd, dec_stall);
    end
    next_cycle();
    issue_valid = 1'b0; issue_is_load = 1'b0;
    @(negedge clk);
    vectors++;
    if (pending !== 32'h200) begin
      miscompares++;
      $display("FAIL col_set_wins: got pending=%h, expected 00000200", pending);
    end
    lsu_wb_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9a;
    exp_q.push_back({5'd9, 32'h9a});
    next_cycle();
    lsu_wb_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    vectors++;
    if (pending !== 32'h0) begin
      miscompares++;
      $display("FAIL col_cleanup: got pending=%h, expected 0", pending);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    for (int i = 1; i <= 10; i++) begin
      ex_wb_valid = 1'b1; ex_rd = 5'(10 + i); ex_data = 32'(32'h100 + i);
      lsu_wb_valid = (i <= 5); lsu_rd = 5'd12; lsu_data = 32'habcd;
      if (i == 5) begin
        exp_q.push_back({5'd12, 32'habcd});
      end else begin
        exp_q.push_back({5'(10 + i), 32'(32'h100 + i)});
      end
      @(negedge clk);
      vectors++;
      if ({ex_hold, lsu_wb_ready, err_drop} !== {(i == 5), (i == 5), (i >= 6)}) begin
        miscompares++;
        $display("FAIL starve_cyc%0d: got hold=%b ready=%b err=%b, expected %b %b %b",
                 i, ex_hold, lsu_wb_ready, err_drop, (i == 5), (i == 5), (i >= 6));
      end
      next_cycle();
    end
    ex_wb_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wb_en, wb_rd} !== {1'b1, 5'd20}) begin
      miscompares++;
      $display("FAIL starve_tail: got en=%b rd=%0d, expected 1 20", wb_en, wb_rd);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({err_drop, wb_en, ex_hold} !== 3'b100) begin
      miscompares++;
      $display("FAIL starve_sticky: got err=%b en=%b hold=%b, expected 1 0 0", err_drop, wb_en, ex_hold);
    end
    next_cycle();
  endtask

  task automatic test_reset_midop();
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd3;
    next_cycle();
    issue_valid = 1'b0; issue_is_load = 1'b0;
    @(negedge clk);
    vectors++;
    if (pending !== 32'h8) begin
      miscompares++;
      $display("FAIL midop_pre: got pending=%h, expected 00000008", pending);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({pending, err_drop, wb_en, ex_hold} !== 35'd0) begin
      miscompares++;
      $display("FAIL midop_async: got pending=%h err=%b en=%b hold=%b, expected all 0",
               pending, err_drop, wb_en, ex_hold);
    end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    vectors++;
    if (pending !== 32'h0) begin
      miscompares++;
      $display("FAIL midop_post: got pending=%h, expected 0", pending);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_arbitration();
    test_scoreboard();
    test_x0();
    test_back_to_back();
    test_collision();
    test_starvation();
    test_reset_midop();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Writeback scheduler and load scoreboard for the 32x32 register file. It merges two writeback sources into the single register-file write port: the single-cycle ALU pipe (`ex_*`) and the variable-latency load/store unit (`lsu_*`). It tracks registers with outstanding loads and raises a decode stall on RAW/WAW hazards. It also enforces forward progress for the LSU when the ALU holds the port.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive blocked LSU cycles before `ex_hold` asserts; legal range 1..15.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_wb_valid` in 1: ALU result valid this cycle; cannot be back-pressured.
- `ex_rd` in 5: ALU destination.
- `ex_data` in 32: ALU result.
- `lsu_wb_valid` in 1: load data valid; held with `lsu_rd`/`lsu_data` stable until accepted.
- `lsu_rd` in 5: load destination.
- `lsu_data` in 32: load data.
- `lsu_wb_ready` out 1: combinational; LSU accepted when `lsu_wb_valid && lsu_wb_ready`.
- `issue_valid` in 1: an instruction leaves decode this cycle.
- `issue_is_load` in 1: the issuing instruction is a load.
- `issue_rd` in 5: destination of the issuing instruction.
- `dec_rs1`, `dec_rs2`, `dec_rd` in 5 each: operands of the instruction in decode.
- `dec_stall` out 1: combinational hazard stall to decode.
- `ex_hold` out 1: request to the ALU pipe to present no writeback this cycle.
- `wb_en` out 1: register-file write enable; registered.
- `wb_rd` out 5: register-file write index; registered.
- `wb_data` out 32: register-file write data; registered.
- `pending` out 32: scoreboard; bit i set means a load to xi is outstanding.
- `err_drop` out 1: sticky; set when an ALU writeback is dropped.

## Operation
Grant, evaluated combinationally each cycle:
- If `ex_hold`=1: LSU is granted (`lsu_wb_ready`=1). Any `ex_wb_valid` in this cycle is dropped and sets `err_drop`.
- Otherwise, if `ex_wb_valid`=1: ALU is granted and `lsu_wb_ready`=0.
- Otherwise: `lsu_wb_ready`=1.

Write stage:
- The granted source's rd/data are registered into `wb_rd`/`wb_data` on the next edge.
- `wb_en` is set at the same edge, except when rd==0 (x0 writes are suppressed, so `wb_en`=0).
- `wb_en` is cleared if nothing is granted.
- A registered `wb_src_lsu` flag records which source owns the current write.

Scoreboard:
- Set: bit `issue_rd` is set at the edge when `issue_valid && issue_is_load && !dec_stall && issue_rd!=0`.
- Clear: bit `wb_rd` is cleared at the edge when `wb_en && wb_src_lsu`. This is the same edge at which the register file commits, so decode reads the new value the following cycle.
- Set and clear of the same bit at the same edge: set wins.
- Bit 0 is always 0.

Stall:
- `dec_stall` = `pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd]`, with index 0 masking each term to 0.
- `issue_valid` is ignored while `dec_stall`=1.

Starvation counter (4 bits):
- Increments each cycle `lsu_wb_valid && !lsu_wb_ready`, saturating at `STARVE_LIMIT`.
- Resets to 0 on LSU acceptance or when `lsu_wb_valid`=0.
- `ex_hold` = (counter == `STARVE_LIMIT`).

## Timing
- Reset values: `wb_en`=0, `wb_rd`=0, `wb_data`=0, `pending`=0, `err_drop`=0, counter=0, hence `ex_hold`=0. Reset applies immediately on `rst_n` falling edge, regardless of clock.
- Reset mid-operation: all outstanding load tracking is lost. The LSU is reset by the same `rst_n`.
- Latency: acceptance at cycle N gives `wb_en`=1 during cycle N+1, and the register file is written at the end of N+1.
- `ex_hold` is asserted in the cycle after the counter reaches `STARVE_LIMIT`, i.e. the (`STARVE_LIMIT`+1)-th consecutive blocked cycle. It deasserts the cycle after LSU acceptance.
- Back-to-back writes from alternating sources are sustained at 1 per cycle. There is no bubble.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> `wb_en`=0, `pending`=0, `ex_hold`=0, `err_drop`=0.
- Arbitration: `ex_wb_valid` (x5, 0x11) and `lsu_wb_valid` (x6, 0x22) both asserted in cycle N:
  - N+1: `wb_en`=1, `wb_rd`=5, `wb_data`=0x11, `lsu_wb_ready`(N)=0.
  - N+2: `wb_rd`=6, `wb_data`=0x22, provided ALU is idle at N+1.
- Scoreboard: issue load to x7, then decode with `dec_rs1`=7 -> `dec_stall`=1 until the LSU writes x7. Stall drops the cycle after `wb_en`=1 with `wb_rd`=7; `pending[7]` returns to 0.
- x0: LSU and ALU writebacks to x0 -> `wb_en` stays 0. A load issued to x0 never sets `pending[0]` and never stalls.
- Starvation with `STARVE_LIMIT`=4: `ex_wb_valid`=1 for 10 cycles with the LSU waiting:
  - `ex_hold`=1 on the 5th cycle, and the LSU is accepted that cycle.
  - The ALU writeback in that cycle is dropped and `err_drop`=1 (sticky).
- Set/clear collision: in the same cycle, the LSU write of x9 commits (`wb_en`=1, `wb_rd`=9) and a new load to x9 issues -> `pending[9]` remains 1.
